// File: rtl/vec_pkg.sv
// Shared constants and helpers for the slice packing/unpacking family.
package vec_pkg;

  localparam int unsigned VEC_MSB_FIRST = 1;
  localparam int unsigned VEC_LSB_FIRST = 0;

  // Width of a counter that must hold 0..ratio inclusive.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/slice_packer_word_hold_reg.sv
// Output register with valid/ready load, hold and clear.
module word_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q
);

  // Load wins over consume so a handshake cycle can reload without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/slice_packer.sv
// Width-up converter: packs IN_W-bit slices into OUT_W-bit words.
module slice_packer
  import vec_pkg::*;
#(
  parameter int unsigned IN_W      = 2,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned MSB_FIRST = VEC_MSB_FIRST
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [IN_W-1:0]                       in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_W-1:0]                      out_data,
  output logic [cnt_width(OUT_W/IN_W)-1:0]      out_slices
);

  localparam int unsigned RATIO = OUT_W / IN_W;
  localparam int unsigned CW    = cnt_width(RATIO);
  localparam int unsigned HW    = OUT_W + CW;

  if ((OUT_W % IN_W) != 0 || RATIO < 2) begin : g_bad_params
    $error("slice_packer: OUT_W must be a multiple of IN_W with ratio >= 2");
  end

  logic [OUT_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    pos;
  logic [OUT_W-1:0] acc_ins;
  logic             accept;
  logic             complete;
  logic [HW-1:0]    hold_q;

  // Ready depends only on the held word and the consumer.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (cnt == CW'(RATIO - 1)));

  // Insert the incoming slice into its lane of the accumulator.
  always_comb begin
    acc_ins = acc;
    pos     = (MSB_FIRST != VEC_LSB_FIRST) ? (CW'(RATIO - 1) - cnt) : cnt;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CW'(i) == pos) begin
        acc_ins[i*IN_W +: IN_W] = in_data;
      end
    end
  end

  // Accumulator and slice counter; both clear when a word is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (complete) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_ins;
        cnt <= cnt + CW'(1);
      end
    end
  end

  word_hold_reg #(
    .W (HW)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (complete),
    .d     ({acc_ins, cnt + CW'(1)}),
    .ready (out_ready),
    .valid (out_valid),
    .q     (hold_q)
  );

  assign out_data   = hold_q[HW-1:CW];
  assign out_slices = hold_q[CW-1:0];

endmodule

// File: doc/slice_packer.md
# slice_packer

Parametrised width-up converter: accepts IN_W-bit slices on a valid/ready stream and concatenates them into OUT_W-bit words. Slice order within the word is selectable. A `in_last` flag closes a word early, zero-padded, with a slice count. It sits between narrow serial/byte-lane sources and word-wide consumers, and generalises the team's fixed bit-slice/concatenation handling into a clocked, back-pressured block.

## Interface
- `IN_W`, 2, slice width in bits; ≥1.
- `OUT_W`, 8, output word width; must be a multiple of IN_W.
- `MSB_FIRST`, 1, 1: first slice lands in the top bits; 0: first slice lands in bits [IN_W-1:0].
- Derived: RATIO = OUT_W/IN_W, must be ≥2. CW = $clog2(RATIO+1).
- Elaboration error if OUT_W % IN_W ≠ 0 or RATIO < 2.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  slice present.
- `in_ready`  out  1  block accepts slice this cycle.
- `in_data`  in  IN_W  slice.
- `in_last`  in  1  slice closes the current word early; qualified by in_valid.
- `out_valid`  out  1  word held in output register.
- `out_ready`  in  1  consumer takes word.
- `out_data`  out  OUT_W  packed word.
- `out_slices`  out  CW  number of valid slices in out_data, 1..RATIO.

## Operation
- State: accumulator `acc[OUT_W-1:0]`, slice counter `cnt` (0..RATIO-1), and output register (`out_data`, `out_slices`, `out_valid`).
- Input handshake: slice accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. It is combinational from registered state and out_ready only. It never depends on in_valid, in_data or in_last.
- Placement of accepted slice with index cnt:
  - MSB_FIRST=1: bits [(RATIO-1-cnt)*IN_W +: IN_W].
  - MSB_FIRST=0: bits [cnt*IN_W +: IN_W].
- Completing slice: an accepted slice with cnt == RATIO-1 or in_last = 1.
- On a completing slice:
  - Output register loads acc with the new slice inserted.
  - out_slices = cnt+1 and out_valid = 1.
  - acc clears to 0 and cnt clears to 0.
- On a non-completing slice: slice written into acc; cnt increments.
- Unfilled slice positions in a short word are 0.
- Output handshake: word consumed when out_valid && out_ready. If no completing slice is accepted in that same cycle, out_valid falls to 0.
- No other state machine; behaviour is fully defined by cnt and out_valid.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - out_valid = 0, out_data = 0, out_slices = 0.
  - acc = 0, cnt = 0.
- Consequently in_ready = 1 while in reset and after release.
- Latency: word appears on out_data/out_valid in the cycle after its completing slice is accepted (1 clock).
- Throughput: one slice per clock while out_ready is held 1; one word every RATIO clocks.
- Output stall: out_valid && !out_ready drops in_ready to 0. No slices are accepted, including non-completing ones. acc, cnt and out_* hold.
- Simultaneous output handshake and completing slice: the output register reloads with the new word and out_valid stays 1, with no bubble.
- in_last on the first slice (cnt=0): the word carries one slice, out_slices = 1.
- in_last on slice RATIO-1 produces the same result as a full word: out_slices = RATIO.
- in_last with in_valid=0 is ignored.
- Reset mid-word: partial acc contents and any held output word are discarded. No partial word is emitted.
- out_data, out_slices and out_valid hold stable while out_valid && !out_ready.

## Structure
- Shared package `vec_pkg`:
  - constants `VEC_MSB_FIRST` = 1 and `VEC_LSB_FIRST` = 0;
  - function `cnt_width(ratio)` returning $clog2(ratio+1), reused by future slice_unpacker.
- One sub-module is natural: `word_hold_reg`. It is the OUT_W+CW-bit output register with valid/ready load/hold/clear logic, parametrised on width. slice_packer contains acc, cnt, placement and in_ready logic.

## Test plan
- Full word, MSB first: IN_W=2, OUT_W=8, MSB_FIRST=1, out_ready=1; slices 11,11,01,01 on consecutive clocks.
  - Required: one clock after the 4th slice, out_data = 8'b1111_0101, out_slices = 4, out_valid for exactly 1 clock.
- Full word, LSB first: same slices with MSB_FIRST=0.
  - Required: out_data = 8'b0101_1111, out_slices = 4.
- Early close: MSB_FIRST=1, slices 10, 11 with in_last on the 2nd.
  - Required: out_data = 8'b1011_0000, out_slices = 2. The next word starts at cnt=0.
- Back-pressure: hold out_ready=0 after the first word completes and keep presenting slices.
  - Required: in_ready = 0 and out_data held stable. No slice is lost, and the next word matches its slices once out_ready=1.
- Back-to-back streaming: continuous slices with out_ready=1 for 3 words.
  - Required: in_ready never drops, words are emitted every 4 clocks, and the reload in a handshake cycle shows no bubble.
- Reset mid-word: assert rst_n=0 after 2 slices, asynchronously between edges.
  - Required: out_valid/out_data/out_slices go 0 immediately. After release, 4 new slices yield a word containing only those slices.
